result_reader: RTL and testbench

RESULT_READER -- requirements
Module: result_reader

---
 rtl/result_reader.sv | 176 +++++++++++++++++
 tb/tb_result_reader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_reader.sv
// result_reader: captures one conversion result, turns the binary count into
// BCD with a serial double-dabble engine, and presents the reading to a
// downstream consumer with a valid/ready handshake. Error and over-range
// results bypass the converter and are presented on the next edge.
module result_reader #(
    parameter int DIGITS          = 6,
    parameter int CONV_BITS       = 20,
    parameter int RANGE_SEL_WIDTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       data_ready_i,
    input  logic [31:0]                result_count_i,
    input  logic [RANGE_SEL_WIDTH-1:0] range_sel_i,
    input  logic                       ref_sign_i,
    input  logic                       error_i,
    input  logic                       ready_i,
    output logic                       valid_o,
    output logic [4*DIGITS-1:0]        bcd_o,
    output logic [RANGE_SEL_WIDTH-1:0] range_o,
    output logic                       neg_o,
    output logic                       overrange_o,
    output logic                       err_o,
    output logic                       overrun_o
);

    localparam int                 BCD_W     = 4 * DIGITS;
    localparam int                 CNT_W     = $clog2(CONV_BITS + 1);
    localparam logic [31:0]        MAX_COUNT = 32'(10 ** DIGITS - 1);
    localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(CONV_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // Display value used when the count does not fit in DIGITS decimal digits.
    function automatic logic [BCD_W-1:0] all_nines();
        logic [BCD_W-1:0] r;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'h9;
        end
        return r;
    endfunction

    // Double-dabble correction: every digit of 5 or more gets +3 before the shift.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = v[4*d +: 4] + 4'd3;
            end else begin
                r[4*d +: 4] = v[4*d +: 4];
            end
        end
        return r;
    endfunction

    state_t                       state_r;
    logic [CONV_BITS-1:0]         shift_r;
    logic [BCD_W-1:0]             acc_r;
    logic [CNT_W-1:0]             step_r;
    logic                         valid_r;
    logic [BCD_W-1:0]             bcd_r;
    logic [RANGE_SEL_WIDTH-1:0]   range_r;
    logic                         neg_r;
    logic                         ovr_r;
    logic                         err_r;
    logic                         overrun_r;

    logic [BCD_W-1:0]             acc_adj_s;
    logic [BCD_W-1:0]             acc_nxt_s;
    logic                         over_s;

    // One double-dabble step: correct digits, then shift in the next count MSB.
    always_comb begin
        acc_adj_s = add3_digits(acc_r);
        acc_nxt_s = BCD_W'({acc_adj_s, shift_r[CONV_BITS-1]});
        over_s    = (result_count_i > MAX_COUNT);
    end

    // Reading FSM: capture in IDLE, serial conversion, hold until handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            acc_r     <= '0;
            step_r    <= '0;
            valid_r   <= 1'b0;
            bcd_r     <= '0;
            range_r   <= '0;
            neg_r     <= 1'b0;
            ovr_r     <= 1'b0;
            err_r     <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (data_ready_i) begin
                        range_r   <= range_sel_i;
                        neg_r     <= ref_sign_i;
                        overrun_r <= 1'b0;
                        if (error_i) begin
                            bcd_r   <= '0;
                            err_r   <= 1'b1;
                            ovr_r   <= 1'b0;
                            valid_r <= 1'b1;
                            state_r <= ST_HOLD;
                        end else if (over_s) begin
                            bcd_r   <= all_nines();
                            err_r   <= 1'b0;
                            ovr_r   <= 1'b1;
                            valid_r <= 1'b1;
                            state_r <= ST_HOLD;
                        end else begin
                            err_r   <= 1'b0;
                            ovr_r   <= 1'b0;
                            shift_r <= result_count_i[CONV_BITS-1:0];
                            acc_r   <= '0;
                            step_r  <= '0;
                            state_r <= ST_CONVERT;
                        end
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                ST_CONVERT: begin
                    if (data_ready_i) begin
                        overrun_r <= 1'b1;
                    end else begin
                        overrun_r <= overrun_r;
                    end
                    acc_r   <= acc_nxt_s;
                    shift_r <= {shift_r[CONV_BITS-2:0], 1'b0};
                    if (step_r == LAST_STEP) begin
                        // Only the finished value ever reaches bcd_o.
                        bcd_r   <= acc_nxt_s;
                        valid_r <= 1'b1;
                        state_r <= ST_HOLD;
                    end else begin
                        step_r  <= step_r + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (data_ready_i) begin
                        overrun_r <= 1'b1;
                    end else begin
                        overrun_r <= overrun_r;
                    end
                    if (ready_i) begin
                        valid_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign valid_o     = valid_r;
    assign bcd_o       = bcd_r;
    assign range_o     = range_r;
    assign neg_o       = neg_r;
    assign overrange_o = ovr_r;
    assign err_o       = err_r;
    assign overrun_o   = overrun_r;

endmodule

// File: tb/tb_result_reader.sv
// Self-checking bench for result_reader: expected readings are computed by a
// decimal-division model, queued at stimulus time and popped when valid_o rises.
module tb_result_reader;

    logic        clk;
    logic        rst_n;
    logic        data_ready;
    logic [31:0] result_count;
    logic [1:0]  range_sel;
    logic        ref_sign;
    logic        error_in;
    logic        ready;
    logic        valid;
    logic [23:0] bcd;
    logic [1:0]  range_out;
    logic        neg;
    logic        overrange;
    logic        err_out;
    logic        overrun;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [23:0] bcd;
        logic [1:0]  rng;
        logic        neg;
        logic        ovr;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    result_reader #(.DIGITS(6), .CONV_BITS(20), .RANGE_SEL_WIDTH(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .data_ready_i   (data_ready),
        .result_count_i (result_count),
        .range_sel_i    (range_sel),
        .ref_sign_i     (ref_sign),
        .error_i        (error_in),
        .ready_i        (ready),
        .valid_o        (valid),
        .bcd_o          (bcd),
        .range_o        (range_out),
        .neg_o          (neg),
        .overrange_o    (overrange),
        .err_o          (err_out),
        .overrun_o      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decimal digits by repeated division.
    function automatic exp_t model(input logic [31:0] count, input logic [1:0] rng,
                                   input logic sign, input logic err);
        exp_t        e;
        logic [31:0] tmp;
        e.rng = rng;
        e.neg = sign;
        e.bcd = 24'h0;
        if (err) begin
            e.err = 1'b1; e.ovr = 1'b0; e.lat = 1;
        end else if (count > 32'd999999) begin
            e.err = 1'b0; e.ovr = 1'b1; e.lat = 1; e.bcd = 24'h999999;
        end else begin
            e.err = 1'b0; e.ovr = 1'b0; e.lat = 21;
            tmp = count;
            for (int d = 0; d < 6; d++) begin
                e.bcd[4*d +: 4] = 4'(tmp % 32'd10);
                tmp = tmp / 32'd10;
            end
        end
        return e;
    endfunction

    // Called right after the capture edge; returns edges until valid_o (bounded).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({valid, bcd, range_out, neg, overrange, err_out, overrun} !== 31'h0)
            $display("FAIL reset_hold: got %h expected 0",
                     {valid, bcd, range_out, neg, overrange, err_out, overrun});
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({valid, bcd, range_out, neg, overrange, err_out, overrun} !== 31'h0)
            $display("FAIL reset_release: got %h expected 0",
                     {valid, bcd, range_out, neg, overrange, err_out, overrun});
        else n_pass++;
    endtask

    // One full reading with ready_i=1: latency, all fields, then valid drop.
    task automatic test_reading(input logic [31:0] count, input logic [1:0] rng,
                                input logic sign, input logic err);
        exp_t e;
        int   lat;
        sb_q.push_back(model(count, rng, sign, err));
        ready        = 1'b1;
        data_ready   = 1'b1;
        result_count = count;
        range_sel    = rng;
        ref_sign     = sign;
        error_in     = err;
        @(posedge clk); #1;
        data_ready = 1'b0;
        error_in   = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b expected 0", overrun);
        else n_pass++;
        wait_valid(lat);
        e = sb_q.pop_front();
        n_checks++;
        if (lat !== e.lat) $display("FAIL latency(%0d): got %0d expected %0d", count, lat, e.lat);
        else n_pass++;
        n_checks++;
        if (bcd !== e.bcd) $display("FAIL bcd(%0d): got %h expected %h", count, bcd, e.bcd);
        else n_pass++;
        n_checks++;
        if ({range_out, neg} !== {e.rng, e.neg})
            $display("FAIL range_neg(%0d): got %b expected %b", count, {range_out, neg}, {e.rng, e.neg});
        else n_pass++;
        n_checks++;
        if ({overrange, err_out} !== {e.ovr, e.err})
            $display("FAIL ovr_err(%0d): got %b expected %b", count, {overrange, err_out}, {e.ovr, e.err});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (valid !== 1'b0) $display("FAIL valid_drop(%0d): got %b expected 0", count, valid);
        else n_pass++;
    endtask

    task automatic test_overrun();
        exp_t e;
        int   lat;
        int   unstable;
        sb_q.push_back(model(32'd100, 2'd1, 1'b0, 1'b0));
        ready        = 1'b0;
        data_ready   = 1'b1;
        result_count = 32'd100;
        range_sel    = 2'd1;
        ref_sign     = 1'b0;
        @(posedge clk); #1;
        data_ready = 1'b0;
        wait_valid(lat);
        e = sb_q.pop_front();
        n_checks++;
        if (lat !== e.lat) $display("FAIL ovrun_latency: got %0d expected %0d", lat, e.lat);
        else n_pass++;
        unstable = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                data_ready   = 1'b1;
                result_count = 32'd42;
                range_sel    = 2'd3;
                ref_sign     = 1'b1;
            end
            @(posedge clk); #1;
            data_ready = 1'b0;
            if (valid !== 1'b1 || bcd !== e.bcd || range_out !== e.rng || neg !== e.neg)
                unstable++;
        end
        n_checks++;
        if (unstable !== 0) $display("FAIL hold_stable: got %0d unstable cycles expected 0", unstable);
        else n_pass++;
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL overrun_set: got %b expected 1", overrun);
        else n_pass++;
        ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({valid, overrun} !== 2'b01) $display("FAIL ovrun_handshake: got %b expected 01", {valid, overrun});
        else n_pass++;
        test_reading(32'd42, 2'd1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_convert();
        int seen;
        ready        = 1'b1;
        data_ready   = 1'b1;
        result_count = 32'd5000;
        range_sel    = 2'd2;
        ref_sign     = 1'b1;
        @(posedge clk); #1;
        data_ready = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({valid, bcd, range_out, neg, overrange, err_out, overrun} !== 31'h0)
            $display("FAIL reset_async: got %h expected 0",
                     {valid, bcd, range_out, neg, overrange, err_out, overrun});
        else n_pass++;
        #3 rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL no_valid_after_reset: got %0d expected 0", seen);
        else n_pass++;
        test_reading(32'd7, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        sb_q.push_back(model(32'd31415, 2'd3, 1'b0, 1'b0));
        ready        = 1'b1;
        data_ready   = 1'b1;
        result_count = 32'd31415;
        range_sel    = 2'd3;
        ref_sign     = 1'b0;
        @(posedge clk); #1;
        data_ready = 1'b0;
        wait_valid(lat);
        e = sb_q.pop_front();
        n_checks++;
        if (bcd !== e.bcd) $display("FAIL b2b_first: got %h expected %h", bcd, e.bcd);
        else n_pass++;
        // Pulse on the handshake edge: must be dropped.
        data_ready   = 1'b1;
        result_count = 32'd999;
        @(posedge clk); #1;
        n_checks++;
        if ({valid, overrun} !== 2'b01) $display("FAIL b2b_drop: got %b expected 01", {valid, overrun});
        else n_pass++;
        // First IDLE cycle: accepted.
        sb_q.push_back(model(32'd271828, 2'd2, 1'b1, 1'b0));
        result_count = 32'd271828;
        range_sel    = 2'd2;
        ref_sign     = 1'b1;
        @(posedge clk); #1;
        data_ready = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL b2b_accept: got %b expected 0", overrun);
        else n_pass++;
        wait_valid(lat);
        e = sb_q.pop_front();
        n_checks++;
        if (lat !== e.lat) $display("FAIL b2b_latency: got %0d expected %0d", lat, e.lat);
        else n_pass++;
        n_checks++;
        if ({bcd, range_out, neg} !== {e.bcd, e.rng, e.neg})
            $display("FAIL b2b_second: got %h expected %h", {bcd, range_out, neg}, {e.bcd, e.rng, e.neg});
        else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        data_ready   = 1'b0;
        result_count = 32'd0;
        range_sel    = 2'd0;
        ref_sign     = 1'b0;
        error_in     = 1'b0;
        ready        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_reading(32'd123456, 2'd2, 1'b1, 1'b0);
        test_reading(32'd1000000, 2'd1, 1'b0, 1'b0);
        test_reading(32'd999999, 2'd0, 1'b0, 1'b0);
        test_reading(32'hFFFF_FFFF, 2'd3, 1'b1, 1'b0);
        test_reading(32'd555, 2'd1, 1'b1, 1'b1);
        test_reading(32'd0, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            test_reading(32'($urandom_range(0, 999999)), 2'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), 1'b0);
        end
        test_overrun();
        test_reset_mid_convert();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
